mem_arbiter: RTL

Arbitrates one tagged memory port between the instruction-fetch requester and the MEM-stage data requester of the 5-stage pipeline, so both can run from a single unified memory instead of separate IM and DM instances. It forwards at most one command per cycle, records which requester owns each outstanding load tag, and routes returned data back to that owner. It sits between `processor` and one `mem` instance.

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one tagged memory port between instruction fetch and the MEM-stage data
// requester, tracking which side owns each outstanding load tag.
module mem_arbiter #(
    parameter int STARVE_LIMIT    = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  im_command,
    input  logic [31:0] im_addr,
    input  logic [31:0] im_data,
    output logic [3:0]  im_response,
    output logic [31:0] im_rdata,
    output logic [3:0]  im_tag,
    input  logic [1:0]  dm_command,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_data,
    output logic [3:0]  dm_response,
    output logic [31:0] dm_rdata,
    output logic [3:0]  dm_tag,
    output logic [1:0]  mem_command,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    input  logic [3:0]  mem_response,
    input  logic [31:0] mem_rdata,
    input  logic [3:0]  mem_tag,
    output logic        grant_dm,
    output logic [3:0]  outstanding,
    output logic        tag_err
);

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_LOAD = 2'd1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [3:0] MAX_OUT    = 4'(MAX_OUTSTANDING);

    // Tag table: owner bit is 1 for the data requester, 0 for fetch.
    logic [15:0] valid_q, valid_d;
    logic [15:0] owner_q, owner_d;
    logic [3:0]  outstanding_q, outstanding_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        tag_err_q, tag_err_d;

    logic im_active, dm_active;
    logic loads_blocked;
    logic im_eligible, dm_eligible;
    logic sel_im, sel_dm;
    logic load_accepted;
    logic ret_hit, ret_miss;

    always_comb begin
        im_active     = (im_command != CMD_NONE);
        dm_active     = (dm_command != CMD_NONE);
        loads_blocked = (outstanding_q == MAX_OUT);
        im_eligible   = im_active && !(loads_blocked && im_command == CMD_LOAD);
        dm_eligible   = dm_active && !(loads_blocked && dm_command == CMD_LOAD);
        // Data side normally wins; a starved fetch takes one cycle of priority.
        sel_im        = im_eligible && ((starve_cnt_q == STARVE_LIM) || !dm_eligible);
        sel_dm        = dm_eligible && !sel_im;
    end

    always_comb begin
        mem_command = CMD_NONE;
        mem_addr    = 32'd0;
        mem_data    = 32'd0;
        im_response = 4'd0;
        dm_response = 4'd0;
        if (sel_im) begin
            mem_command = im_command;
            mem_addr    = im_addr;
            mem_data    = im_data;
            im_response = mem_response;
        end else if (sel_dm) begin
            mem_command = dm_command;
            mem_addr    = dm_addr;
            mem_data    = dm_data;
            dm_response = mem_response;
        end
    end

    always_comb begin
        load_accepted = (sel_im || sel_dm) && (mem_command == CMD_LOAD) && (mem_response != 4'd0);
        ret_hit       = (mem_tag != 4'd0) && valid_q[mem_tag];
        ret_miss      = (mem_tag != 4'd0) && !valid_q[mem_tag];
        im_tag        = 4'd0;
        im_rdata      = 32'd0;
        dm_tag        = 4'd0;
        dm_rdata      = 32'd0;
        if (ret_hit) begin
            if (owner_q[mem_tag]) begin
                dm_tag   = mem_tag;
                dm_rdata = mem_rdata;
            end else begin
                im_tag   = mem_tag;
                im_rdata = mem_rdata;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        // Return clears first so a same-tag reissue overwrites with the new owner.
        if (ret_hit) begin
            valid_d[mem_tag] = 1'b0;
        end
        if (load_accepted) begin
            valid_d[mem_response] = 1'b1;
            owner_d[mem_response] = sel_dm;
        end

        outstanding_d = outstanding_q;
        if (load_accepted && !ret_hit && outstanding_q != MAX_OUT) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (ret_hit && !load_accepted && outstanding_q != 4'd0) begin
            outstanding_d = outstanding_q - 4'd1;
        end

        starve_cnt_d = 4'd0;
        if (im_active && im_response == 4'd0) begin
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 4'd1;
        end

        tag_err_d = tag_err_q | ret_miss;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= 16'd0;
            owner_q       <= 16'd0;
            outstanding_q <= 4'd0;
            starve_cnt_q  <= 4'd0;
            tag_err_q     <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            owner_q       <= owner_d;
            outstanding_q <= outstanding_d;
            starve_cnt_q  <= starve_cnt_d;
            tag_err_q     <= tag_err_d;
        end
    end

    assign grant_dm    = sel_dm;
    assign outstanding = outstanding_q;
    assign tag_err     = tag_err_q;

endmodule
